// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: program-memory read port plus decoder handoff.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [15:0]       instr;
  logic              id_en;
  logic              stall;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data,
    output instr,
    output id_en,
    input  stall
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data,
    input  instr,
    input  id_en,
    output stall
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the PC through a 1-cycle-latency program
// memory and strobes each word to the decoder; handles stall, branch, halt.
module instr_fetch #(
  parameter int         ADDR_W  = 8,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_branch_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted,
  instr_fetch_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic              w_halt_op;
  logic              w_busy;
  logic              w_mem_rd;
  logic              w_id_en;
  logic              w_halted;

  assign w_halt_op = (r_instr[15:12] == HALT_OP);
  assign w_busy    = (r_state == S_FETCH) ||
                     (r_state == S_WAIT)  ||
                     (r_state == S_ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_FETCH;
      S_FETCH: w_next = i_branch_en ? S_FETCH : S_WAIT;
      S_WAIT:  w_next = i_branch_en ? S_FETCH : S_ISSUE;
      S_ISSUE: begin
        if (i_branch_en)  w_next = S_FETCH;
        else if (bus.stall) w_next = S_ISSUE;
        else if (w_halt_op) w_next = S_HALT;
        else              w_next = S_FETCH;
      end
      S_HALT:  if (i_start) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_rd = 1'b0;
    w_id_en  = 1'b0;
    w_halted = 1'b0;
    unique case (r_state)
      S_FETCH: w_mem_rd = 1'b1;
      S_ISSUE: w_id_en  = !bus.stall && !i_branch_en;
      S_HALT:  w_halted = 1'b1;
      default: ;
    endcase
  end

  // A branch in WAIT drops the in-flight word, so instr keeps its old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      r_instr <= 16'h0000;
    end else begin
      if ((r_state == S_IDLE || r_state == S_HALT) && i_start)
        r_pc <= '0;
      else if (w_busy && i_branch_en)
        r_pc <= i_branch_addr;
      else if (r_state == S_ISSUE && !bus.stall && !w_halt_op)
        r_pc <= r_pc + 1'b1;

      if (r_state == S_WAIT && !i_branch_en)
        r_instr <= bus.mem_data;
    end
  end

  assign bus.mem_rd   = w_mem_rd;
  assign bus.mem_addr = r_pc;
  assign bus.instr    = r_instr;
  assign bus.id_en    = w_id_en;
  assign o_pc         = r_pc;
  assign o_halted     = w_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall, branch, halt,
// wrap-around and asynchronous reset, against a 1-cycle-latency memory.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic        branch_en;
  logic [7:0]  branch_addr;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] mem [256];
  int          checks;
  int          passes;
  int          fails;

  instr_fetch_if #(.ADDR_W(8)) bus ();

  instr_fetch #(.ADDR_W(8), .HALT_OP(4'hF)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (start),
    .i_branch_en   (branch_en),
    .i_branch_addr (branch_addr),
    .o_pc          (pc),
    .o_halted      (halted),
    .bus           (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1041;
    mem[8'h01] = 16'h2082;
    mem[8'h02] = 16'h30C3;
    mem[8'h03] = 16'hF000;
    mem[8'h40] = 16'h5555;
    mem[8'hFF] = 16'h1000;
    bus.mem_data = 16'h0000;
    bus.stall    = 1'b0;
    start        = 1'b0;
    branch_en    = 1'b0;
    branch_addr  = 8'h00;
    reset        = 1'b1;
    #12;
    chk("rst_pc",     {8'h0, pc}, 16'h0000);
    chk("rst_instr",  bus.instr, 16'h0000);
    chk("rst_id_en",  {15'h0, bus.id_en}, 16'h0000);
    chk("rst_mem_rd", {15'h0, bus.mem_rd}, 16'h0000);
    chk("rst_halted", {15'h0, halted}, 16'h0000);
    reset = 1'b0;
    tick();
    chk("idle_no_rd", {15'h0, bus.mem_rd}, 16'h0000);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c1_mem_rd", {15'h0, bus.mem_rd}, 16'h0001);
    chk("c1_addr",   {8'h0, bus.mem_addr}, 16'h0000);
    chk("c1_id_en",  {15'h0, bus.id_en}, 16'h0000);
    tick();
    chk("c2_id_en",  {15'h0, bus.id_en}, 16'h0000);
    chk("c2_mem_rd", {15'h0, bus.mem_rd}, 16'h0000);
    tick();
    chk("c3_id_en",  {15'h0, bus.id_en}, 16'h0001);
    chk("c3_instr",  bus.instr, 16'h1041);
    tick();
    chk("c4_id_en",  {15'h0, bus.id_en}, 16'h0000);
    chk("c4_addr",   {8'h0, bus.mem_addr}, 16'h0001);
    tick();
    bus.stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall_id_en", {15'h0, bus.id_en}, 16'h0000);
      chk("stall_instr", bus.instr, 16'h2082);
      chk("stall_pc",    {8'h0, pc}, 16'h0001);
      tick();
    end
    bus.stall = 1'b0;
    #1;
    chk("unstall_id_en", {15'h0, bus.id_en}, 16'h0001);
    chk("unstall_instr", bus.instr, 16'h2082);
    tick();
    chk("adv_pc",    {8'h0, pc}, 16'h0002);
    chk("adv_rd",    {15'h0, bus.mem_rd}, 16'h0001);
    tick();
    tick();
    chk("w2_id_en",  {15'h0, bus.id_en}, 16'h0001);
    chk("w2_instr",  bus.instr, 16'h30C3);
    tick();
    chk("w3_addr",   {8'h0, bus.mem_addr}, 16'h0003);
    tick();
    tick();
    chk("halt_id_en",  {15'h0, bus.id_en}, 16'h0001);
    chk("halt_instr",  bus.instr, 16'hF000);
    chk("halt_not_yet", {15'h0, halted}, 16'h0000);
    tick();
    chk("halted",      {15'h0, halted}, 16'h0001);
    chk("halt_pc",     {8'h0, pc}, 16'h0003);
    chk("halt_rd",     {15'h0, bus.mem_rd}, 16'h0000);
    chk("halt_id_off", {15'h0, bus.id_en}, 16'h0000);
    branch_en   = 1'b1;
    branch_addr = 8'h40;
    tick();
    branch_en = 1'b0;
    tick();
    chk("halt_br_ign", {15'h0, halted}, 16'h0001);
    chk("halt_br_pc",  {8'h0, pc}, 16'h0003);
    chk("halt_br_rd",  {15'h0, bus.mem_rd}, 16'h0000);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_halted", {15'h0, halted}, 16'h0000);
    chk("rs_addr",   {8'h0, bus.mem_addr}, 16'h0000);
    chk("rs_rd",     {15'h0, bus.mem_rd}, 16'h0001);
    tick();
    tick();
    chk("rs_id_en",  {15'h0, bus.id_en}, 16'h0001);
    chk("rs_instr",  bus.instr, 16'h1041);
    tick();
    chk("rs_addr1",  {8'h0, bus.mem_addr}, 16'h0001);
    tick();
    branch_en   = 1'b1;
    branch_addr = 8'h40;
    tick();
    branch_en = 1'b0;
    chk("br_addr",   {8'h0, bus.mem_addr}, 16'h0040);
    chk("br_rd",     {15'h0, bus.mem_rd}, 16'h0001);
    chk("br_drop",   bus.instr, 16'h1041);
    tick();
    chk("br_wait",   {15'h0, bus.id_en}, 16'h0000);
    tick();
    chk("br_id_en",  {15'h0, bus.id_en}, 16'h0001);
    chk("br_instr",  bus.instr, 16'h5555);

    branch_en   = 1'b1;
    branch_addr = 8'hFF;
    #1;
    chk("br_iss_id", {15'h0, bus.id_en}, 16'h0000);
    tick();
    branch_en = 1'b0;
    chk("wr_addr",   {8'h0, bus.mem_addr}, 16'h00FF);
    tick();
    tick();
    chk("wr_id_en",  {15'h0, bus.id_en}, 16'h0001);
    chk("wr_instr",  bus.instr, 16'h1000);
    tick();
    chk("wr_pc0",    {8'h0, pc}, 16'h0000);
    chk("wr_rd",     {15'h0, bus.mem_rd}, 16'h0001);
    tick();

    #2;
    reset = 1'b1;
    #1;
    chk("ar_pc",     {8'h0, pc}, 16'h0000);
    chk("ar_instr",  bus.instr, 16'h0000);
    chk("ar_rd",     {15'h0, bus.mem_rd}, 16'h0000);
    chk("ar_id_en",  {15'h0, bus.id_en}, 16'h0000);
    chk("ar_halted", {15'h0, halted}, 16'h0000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_id", {15'h0, bus.id_en}, 16'h0000);
      chk("post_rst_rd", {15'h0, bus.mem_rd}, 16'h0000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the producer side of the instruction-decoder interface. It sequences a program counter through a synchronous program memory and presents each 16-bit instruction word to the decoder with a one-cycle `id_en` strobe. It supports stall back-pressure, taken branches and a halt opcode. It sits between program memory and the instruction decoder, whose fields are opcode [15:12], parameter1 [11:6] and parameter2 [5:0].

## Interface
- `ADDR_W`, 8: program-memory address width; the PC wraps modulo 2^ADDR_W.
- `HALT_OP`, 4'hF: opcode in instr[15:12] that stops fetching.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin fetching from address 0; honoured only in IDLE or HALT.
- `stall`  in  1  decoder not ready; holds the current instruction.
- `branch_en`  in  1  redirect fetch; honoured only in FETCH, WAIT or ISSUE.
- `branch_addr`  in  ADDR_W  branch target.
- `mem_rd`  out  1  program-memory read strobe.
- `mem_addr`  out  ADDR_W  program-memory address (equals `pc`).
- `mem_data`  in  16  read data, valid the cycle after `mem_rd` (1-cycle latency).
- `instr`  out  16  registered instruction word for the decoder.
- `id_en`  out  1  instruction valid; the decoder latches `instr` on the edge ending this cycle.
- `pc`  out  ADDR_W  address of the instruction being fetched or issued.
- `halted`  out  1  high while in HALT.

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, HALT. Reset state: IDLE.
- IDLE:
  - `start`=1 → pc←0, go to FETCH.
- FETCH:
  - `mem_rd`=1 and `mem_addr`=pc.
  - Go to WAIT.
- WAIT:
  - `instr`←`mem_data` at the end of the cycle.
  - Go to ISSUE.
- ISSUE:
  - `id_en` = !stall && !branch_en (combinational from state and inputs).
  - stall=1 → stay in ISSUE; `instr` and pc held.
  - stall=0 and instr[15:12]≠HALT_OP → pc←pc+1 (wraps 2^ADDR_W−1→0), go to FETCH.
  - stall=0 and instr[15:12]=HALT_OP → the halt word is issued (`id_en`=1), pc not incremented, go to HALT.
- HALT:
  - `halted`=1.
  - `start`=1 → pc←0, go to FETCH.
  - `branch_en` ignored.
- Branch: `branch_en`=1 in FETCH, WAIT or ISSUE → pc←branch_addr, go to FETCH.
  - The in-flight word is discarded: `instr` is not loaded if the branch occurs in WAIT.
  - `id_en`=0 in that cycle.
  - Priority: reset > branch_en > stall > halt decode.
- `start` outside IDLE/HALT is ignored. `stall` outside ISSUE is ignored.
- `mem_rd`=0 in every state except FETCH. `mem_addr` always drives pc.

## Timing
- Reset values: state=IDLE, pc=0, `instr`=16'h0000, `id_en`=0, `mem_rd`=0, `mem_addr`=0, `halted`=0. Reset is effective immediately and abandons any fetch in progress.
- Sequence after `start` is sampled at edge E0:
  - FETCH in cycle 1.
  - WAIT in cycle 2.
  - ISSUE in cycle 3, with `id_en`=1 and `instr`=mem[0].
- Throughput: 3 cycles per instruction without stalls. `id_en` is never high in two consecutive cycles.
- Each stall cycle adds one cycle. `id_en` rises in the first cycle in which stall=0.
- Branch sampled at edge Eb → FETCH of branch_addr in the following cycle; the first `id_en` for the target comes 3 cycles after Eb.
- `halted` rises in the cycle after the halt word's `id_en` cycle.

## Test plan
- Sequential fetch:
  - Stimulus: mem[0..2]=16'h1041, 16'h2082, 16'h30C3; pulse start.
  - Required response: `id_en` pulses in cycles 3, 6, 9 carrying those words in order; `mem_addr` goes 0, 1, 2.
- Stall:
  - Stimulus: hold stall=1 for 4 cycles during the ISSUE of mem[1].
  - Required response: `instr` stays 16'h2082 and `id_en`=0 for those 4 cycles; `id_en`=1 on the cycle stall drops; pc then advances to 2.
- Branch:
  - Stimulus: mem[0x40]=16'h5555; assert branch_en with branch_addr=8'h40 during WAIT of address 1.
  - Required response: mem[1] is never issued; `mem_addr`=0x40 on the next cycle; `id_en` with 16'h5555 three cycles after the branch edge.
- Halt and restart:
  - Stimulus: mem[3]=16'hF000, then pulse start.
  - Required response: 16'hF000 is issued with `id_en`=1; `halted`=1 next cycle; pc stays 3 and `mem_rd` stays 0 thereafter. Start then restarts at address 0 and `halted` drops.
- Wrap-around:
  - Stimulus: branch to 8'hFF with mem[0xFF]=16'h1000.
  - Required response: after issue, pc wraps to 0 and mem[0] is fetched.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously during WAIT.
  - Required response: all outputs return to reset values immediately; no `id_en` until the next start.
